// File: rtl/complex_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | complex_divider: result = a/b as a*conj(b)/|b|^2, restoring division,     |
// | one quotient bit per cycle on both components.      Rev 1.0               |
// +--------------------------------------------------------------------------+
module complex_divider #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic                 busy,
  output logic                 div_by_zero,
  output logic [2*WIDTH-1:0]   result
);

  localparam int c_H  = WIDTH / 2;
  localparam int c_CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);
  localparam logic [c_CW-1:0]  c_LAST = c_CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state, w_next_state;

  logic [WIDTH-1:0]        r_a, r_b, r_d;
  logic [c_CW-1:0]         r_cnt;
  logic                    w_accept, w_bzero, w_last;
  logic signed [WIDTH-1:0] w_arx, w_aix, w_brx, w_bix;
  logic signed [WIDTH-1:0] w_p_rr, w_p_ii, w_p_ir, w_p_ri, w_sq_r, w_sq_i;
  logic [WIDTH:0]          w_nr, w_ni;
  logic [WIDTH-1:0]        w_d;
  logic [1:0][WIDTH-1:0]   w_mag, w_q_signed;
  logic [1:0]              w_neg;

  assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_bzero  = (r_b == '0);
  assign w_last   = (r_cnt == c_LAST);

  assign w_arx = {{c_H{r_a[c_H-1]}}, r_a[c_H-1:0]};
  assign w_aix = {{c_H{r_a[WIDTH-1]}}, r_a[WIDTH-1:c_H]};
  assign w_brx = {{c_H{r_b[c_H-1]}}, r_b[c_H-1:0]};
  assign w_bix = {{c_H{r_b[WIDTH-1]}}, r_b[WIDTH-1:c_H]};

  assign w_p_rr = w_arx * w_brx;
  assign w_p_ii = w_aix * w_bix;
  assign w_p_ir = w_aix * w_brx;
  assign w_p_ri = w_arx * w_bix;
  assign w_sq_r = w_brx * w_brx;
  assign w_sq_i = w_bix * w_bix;

  // One extra bit on the numerators: (-2^(H-1))^2 * 2 does not fit 2H signed.
  assign w_nr = {w_p_rr[WIDTH-1], w_p_rr} + {w_p_ii[WIDTH-1], w_p_ii};
  assign w_ni = {w_p_ir[WIDTH-1], w_p_ir} - {w_p_ri[WIDTH-1], w_p_ri};
  assign w_d  = w_sq_r + w_sq_i;

  assign w_neg[0] = w_nr[WIDTH];
  assign w_neg[1] = w_ni[WIDTH];
  assign w_mag[0] = w_nr[WIDTH] ? (~w_nr[WIDTH-1:0] + c_ONE) : w_nr[WIDTH-1:0];
  assign w_mag[1] = w_ni[WIDTH] ? (~w_ni[WIDTH-1:0] + c_ONE) : w_ni[WIDTH-1:0];

  // Lane 0 = real, lane 1 = imaginary; both divide by the same r_d.
  for (genvar k = 0; k < 2; k++) begin : g_lane
    logic [WIDTH-1:0] r_rem, r_quo, w_quo_nx;
    logic             r_neg, w_ge;
    logic [WIDTH:0]   w_trial, w_diff;

    assign w_trial  = {r_rem, r_quo[WIDTH-1]};
    assign w_diff   = w_trial - {1'b0, r_d};
    assign w_ge     = ~w_diff[WIDTH];
    assign w_quo_nx = {r_quo[WIDTH-2:0], w_ge};
    assign w_q_signed[k] = r_neg ? (~w_quo_nx + c_ONE) : w_quo_nx;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rem <= '0;
        r_quo <= '0;
        r_neg <= 1'b0;
      end else if (r_state == S_PREP) begin
        r_rem <= '0;
        r_quo <= w_mag[k];
        r_neg <= w_neg[k];
      end else if (r_state == S_DIV) begin
        r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
        r_quo <= w_quo_nx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_PREP;
      end
      S_PREP: begin
        busy         = 1'b1;
        w_next_state = w_bzero ? S_DONE : S_DIV;
      end
      S_DIV: begin
        busy = 1'b1;
        if (w_last) w_next_state = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_next_state = start ? S_PREP : S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a <= a;
        r_b <= b;
      end
      if (r_state == S_PREP) begin
        r_d   <= w_d;
        r_cnt <= '0;
        if (w_bzero) begin
          result      <= '0;
          div_by_zero <= 1'b1;
        end
      end else if (r_state == S_DIV) begin
        r_cnt <= r_cnt + c_CW'(1);
        if (w_last) begin
          result      <= {w_q_signed[1], w_q_signed[0]};
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_complex_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_complex_divider: scoreboard bench for complex_divider, WIDTH=8.       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_complex_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic        done, busy, div_by_zero;
  logic [15:0] result;

  complex_divider #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .done(done), .busy(busy), .div_by_zero(div_by_zero), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] res;
    logic        dbz;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  function automatic logic [16:0] model(input logic [7:0] ia, input logic [7:0] ib);
    int ar, ai, br, bi, nr, ni, d, qr, qi;
    logic [7:0] rr, ri;
    ar = $signed(ia[3:0]);
    ai = $signed(ia[7:4]);
    br = $signed(ib[3:0]);
    bi = $signed(ib[7:4]);
    if (ib == 8'h00) return {1'b1, 16'h0000};
    nr = ar * br + ai * bi;
    ni = ai * br - ar * bi;
    d  = br * br + bi * bi;
    qr = nr / d;
    qi = ni / d;
    rr = qr[7:0];
    ri = qi[7:0];
    return {1'b0, ri, rr};
  endfunction

  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [15:0] eres,
                       input logic edbz, input bit hold, input bit now);
    exp_t e;
    if (!now) @(negedge clk);
    a = ia;
    b = ib;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.res = eres;
    e.dbz = edbz;
    e.cyc = cyc + (edbz ? 1 : 9);
    sb.push_back(e);
    if (!hold) begin
      start = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
    end
  endtask

  task automatic collect(input string name);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: done=%b after %0d cycles, required 1", name, done, n);
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected done: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      if (result !== e.res) begin
        errors++;
        $display("FAIL %s result: got %h, required %h", name, result, e.res);
      end
      checks++;
      if (div_by_zero !== e.dbz) begin
        errors++;
        $display("FAIL %s div_by_zero: got %b, required %b", name, div_by_zero, e.dbz);
      end
      checks++;
      if (cyc !== e.cyc) begin
        errors++;
        $display("FAIL %s latency: done at cycle %0d, required %0d", name, cyc, e.cyc);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({done, busy, div_by_zero, result} !== 19'h0) begin
      errors++;
      $display("FAIL reset outputs: got %b/%b/%b/%h, required 0/0/0/0000",
               done, busy, div_by_zero, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    issue(8'h55, 8'h21, 16'hFF03, 1'b0, 0, 0); collect("vec_5p5i_div_1p2i");
    issue(8'h07, 8'h02, 16'h0003, 1'b0, 0, 0); collect("vec_trunc_pos");
    issue(8'h09, 8'h02, 16'h00FD, 1'b0, 0, 0); collect("vec_trunc_neg");
    issue(8'h88, 8'h01, 16'hF8F8, 1'b0, 0, 0); collect("vec_extreme_div1");
    issue(8'h88, 8'h88, 16'h0001, 1'b0, 0, 0); collect("vec_extreme_self");
    issue(8'h55, 8'h00, 16'h0000, 1'b1, 0, 0); collect("vec_div_by_zero");
  endtask

  task automatic test_random();
    logic [7:0]  ra, rb;
    logic [16:0] m;
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      m  = model(ra, rb);
      issue(ra, rb, m[15:0], m[16], 0, 0);
      collect("random");
    end
  endtask

  task automatic test_handshake();
    issue(8'h55, 8'h21, 16'hFF03, 1'b0, 1, 0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL handshake busy step %0d: got %b, required 1", i, busy);
      end
    end
    start = 1'b0;
    collect("handshake_held");
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL handshake re-accept: done=%b busy=%b, required 0/0", done, busy);
    end
  endtask

  task automatic test_ignore_busy();
    issue(8'h55, 8'h21, 16'hFF03, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    a = 8'h07;
    b = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect("ignore_start_busy");
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_busy extra op: done=%b busy=%b, required 0/0", done, busy);
    end
  endtask

  task automatic test_back_to_back();
    issue(8'h55, 8'h00, 16'h0000, 1'b1, 0, 0);
    collect("b2b_first_dbz");
    issue(8'h55, 8'h21, 16'hFF03, 1'b0, 0, 1);
    checks++;
    if (busy !== 1'b1 || div_by_zero !== 1'b1 || result !== 16'h0000) begin
      errors++;
      $display("FAIL b2b held outputs: busy=%b dbz=%b result=%h, required 1/1/0000",
               busy, div_by_zero, result);
    end
    collect("b2b_second");
    issue(8'h07, 8'h02, 16'h0003, 1'b0, 0, 1);
    collect("b2b_third");
  endtask

  task automatic test_reset_mid();
    issue(8'h09, 8'h02, 16'h00FD, 1'b0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({done, busy, div_by_zero, result} !== 19'h0) begin
      errors++;
      $display("FAIL reset_mid outputs: got %b/%b/%b/%h, required 0/0/0/0000",
               done, busy, div_by_zero, result);
    end
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid done during reset: got %b, required 0", done);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid stale done: got %b, required 0", done);
      end
    end
    issue(8'h55, 8'h21, 16'hFF03, 1'b0, 0, 0);
    collect("reset_mid_next_op");
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_handshake();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
